// File: rtl/lab2_pkg.sv
// Shared constants for the dual-digit display path, plus the per-cycle
// decision helper used by each debounced switch bank.
package lab2_pkg;

  localparam int DIGIT_W                 = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 480000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_RESTART = 2'd1,
    DB_COUNT   = 2'd2,
    DB_ACCEPT  = 2'd3
  } db_action_e;

  // Decide what a bank does this cycle from three comparisons on the synchronised sample.
  function automatic db_action_e db_classify(
    input logic q_eq_out,
    input logic q_eq_cand,
    input logic run_done
  );
    db_action_e action;
    if (q_eq_out) begin
      action = DB_IDLE;
    end else if (run_done) begin
      action = DB_ACCEPT;
    end else if (!q_eq_cand) begin
      action = DB_RESTART;
    end else begin
      action = DB_COUNT;
    end
    return action;
  endfunction

endpackage

// File: rtl/switch_conditioner_debounce_bank.sv
// One WIDTH-bit switch bank: input synchroniser followed by whole-nibble
// debounce (candidate, run counter, registered output and change strobe).
module debounce_bank
  import lab2_pkg::*;
#(
  parameter int WIDTH           = DIGIT_W,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_value,
  output logic             o_changed,
  output logic             o_idle
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The cand/cnt/out registers capture the synchroniser output directly and
  // serve as its final stage, so only SYNC_STAGES-1 dedicated flops are needed.
  localparam int CHAIN = (SYNC_STAGES > 1) ? SYNC_STAGES - 1 : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] r_sync [CHAIN];
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_value;
  logic [CNT_W-1:0] r_cnt;
  logic             r_changed;

  logic [WIDTH-1:0] w_q;
  logic [CNT_W-1:0] w_run_len;
  db_action_e       w_action;

  assign w_q = r_sync[CHAIN-1];

  // Length of the current run of identical samples, and the resulting action.
  always_comb begin
    w_run_len = CNT_ONE;
    if (w_q == r_cand) begin
      w_run_len = r_cnt + CNT_ONE;
    end else begin
      w_run_len = CNT_ONE;
    end
    w_action = db_classify(w_q == r_value, w_q == r_cand, w_run_len == CNT_LAST);
  end

  // Synchroniser shift plus debounce state update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHAIN; i++) begin
        r_sync[i] <= {WIDTH{1'b0}};
      end
      r_cand    <= {WIDTH{1'b0}};
      r_value   <= {WIDTH{1'b0}};
      r_cnt     <= CNT_ZERO;
      r_changed <= 1'b0;
    end else begin
      r_sync[0] <= i_raw;
      for (int i = 1; i < CHAIN; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_changed <= 1'b0;
      case (w_action)
        DB_IDLE: begin
          r_cnt  <= CNT_ZERO;
          r_cand <= r_value;
        end
        DB_RESTART: begin
          r_cand <= w_q;
          r_cnt  <= CNT_ONE;
        end
        DB_COUNT: begin
          r_cnt <= w_run_len;
        end
        DB_ACCEPT: begin
          r_value   <= w_q;
          r_cand    <= w_q;
          r_cnt     <= CNT_ZERO;
          r_changed <= 1'b1;
        end
        default: begin
          r_cnt  <= CNT_ZERO;
          r_cand <= r_value;
        end
      endcase
    end
  end

  assign o_value   = r_value;
  assign o_changed = r_changed;
  assign o_idle    = (r_cnt == CNT_ZERO);

endmodule

// File: rtl/switch_conditioner.sv
// Front end for the dual-digit display: two independent debounced switch
// banks plus a registered flag showing that neither bank has a change pending.
module switch_conditioner
  import lab2_pkg::*;
#(
  parameter int WIDTH           = DIGIT_W,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s1_raw,
  input  logic [WIDTH-1:0] s2_raw,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic             s1_changed,
  output logic             s2_changed,
  output logic             settled
);

  logic w_idle1;
  logic w_idle2;
  logic r_settled;

  debounce_bank #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_bank1 (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (s1_raw),
    .o_value  (s1),
    .o_changed(s1_changed),
    .o_idle   (w_idle1)
  );

  debounce_bank #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_bank2 (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (s2_raw),
    .o_value  (s2),
    .o_changed(s2_changed),
    .o_idle   (w_idle2)
  );

  // Settled flag follows both counters being idle, one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settled <= 1'b1;
    end else begin
      r_settled <= w_idle1 && w_idle2;
    end
  end

  assign settled = r_settled;

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner: directed scenarios and random
// bouncing inputs compared against a sliding-window reference model.
module tb_switch_conditioner;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] s1_raw = 4'h0;
  logic [W-1:0] s2_raw = 4'h0;
  logic [W-1:0] s1, s2;
  logic         s1_changed, s2_changed, settled;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a value is accepted once the last DC synchronised
  // samples all equal it and it differs from the current output.
  logic [W-1:0] m_out  [2];
  logic [W-1:0] m_win  [2][DC];
  logic [W-1:0] m_dly  [2][SS-1];
  logic         m_chg  [2];
  logic         m_idle [2];
  logic         m_settled;

  switch_conditioner #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s1_raw    (s1_raw),
    .s2_raw    (s2_raw),
    .s1        (s1),
    .s2        (s2),
    .s1_changed(s1_changed),
    .s2_changed(s2_changed),
    .settled   (settled)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_edge(input logic [W-1:0] r1, input logic [W-1:0] r2, input logic rst);
    logic [W-1:0] raw [2];
    logic [W-1:0] q;
    logic         all_same;
    raw[0] = r1;
    raw[1] = r2;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_out[b]  = '0;
        m_chg[b]  = 1'b0;
        m_idle[b] = 1'b1;
        for (int k = 0; k < DC; k++) m_win[b][k] = '0;
        for (int k = 0; k < SS-1; k++) m_dly[b][k] = '0;
      end
      m_settled = 1'b1;
    end else begin
      m_settled = m_idle[0] && m_idle[1];
      for (int b = 0; b < 2; b++) begin
        q = m_dly[b][SS-2];
        for (int k = SS-2; k > 0; k--) m_dly[b][k] = m_dly[b][k-1];
        m_dly[b][0] = raw[b];
        for (int k = DC-1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
        m_win[b][0] = q;
        all_same = 1'b1;
        for (int k = 0; k < DC; k++) if (m_win[b][k] != q) all_same = 1'b0;
        m_chg[b] = all_same && (q != m_out[b]);
        if (m_chg[b]) m_out[b] = q;
        m_idle[b] = (q == m_out[b]);
      end
    end
  endtask

  task automatic tick(input logic [W-1:0] r1, input logic [W-1:0] r2, input logic rst, input string tag);
    @(negedge clk);
    reset  = rst;
    s1_raw = r1;
    s2_raw = r2;
    @(posedge clk);
    model_edge(r1, r2, rst);
    #1;
    check_eq({tag, ".s1"}, s1, m_out[0]);
    check_eq({tag, ".s2"}, s2, m_out[1]);
    check_eq({tag, ".s1_changed"}, s1_changed, m_chg[0]);
    check_eq({tag, ".s2_changed"}, s2_changed, m_chg[1]);
    check_eq({tag, ".settled"}, settled, m_settled);
  endtask

  task automatic hold(input logic [W-1:0] r1, input logic [W-1:0] r2, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(r1, r2, 1'b0, tag);
  endtask

  initial begin
    int pulses;
    logic [W-1:0] r1, r2;
    logic         rst;

    // 1: reset with raws present, then both banks qualify together on edge 5
    tick(4'b1010, 4'b0101, 1'b1, "t1_rst");
    check_eq("t1_rst_settled", settled, 1'b1);
    check_eq("t1_rst_s1", s1, 4'h0);
    tick(4'b1010, 4'b0101, 1'b1, "t1_rst");
    for (int i = 1; i <= 5; i++) begin
      tick(4'b1010, 4'b0101, 1'b0, "t1");
      if (i == 4) check_eq("t1_s1_edge4", s1, 4'h0);
    end
    check_eq("t1_s1_edge5", s1, 4'b1010);
    check_eq("t1_s2_edge5", s2, 4'b0101);
    check_eq("t1_strobes", {s1_changed, s2_changed}, 2'b11);
    tick(4'b1010, 4'b0101, 1'b0, "t1_after");
    check_eq("t1_strobes_off", {s1_changed, s2_changed}, 2'b00);

    // 2: s1 0000 -> 0110, s2 untouched
    hold(4'b0000, 4'b0101, 7, "t2_pre");
    for (int i = 1; i <= 5; i++) tick(4'b0110, 4'b0101, 1'b0, "t2");
    check_eq("t2_s1", s1, 4'b0110);
    check_eq("t2_s1_changed", s1_changed, 1'b1);
    check_eq("t2_s2_changed", s2_changed, 1'b0);
    tick(4'b0110, 4'b0101, 1'b0, "t2_after");
    check_eq("t2_s1_changed_off", s1_changed, 1'b0);

    // 3: bounce restarts qualification, single strobe, no partial value
    hold(4'b0000, 4'b0101, 7, "t3_pre");
    pulses = 0;
    hold(4'b0110, 4'b0101, 2, "t3_a");
    tick(4'b0100, 4'b0101, 1'b0, "t3_b");
    for (int i = 0; i < 10; i++) begin
      tick(4'b0110, 4'b0101, 1'b0, "t3_c");
      pulses += int'(s1_changed);
      if (i == 3) check_eq("t3_settled_low", settled, 1'b0);
    end
    check_eq("t3_pulses", pulses, 1);
    check_eq("t3_s1", s1, 4'b0110);

    // 4: two-cycle glitch on s2 is discarded
    hold(4'b0110, 4'b1111, 7, "t4_pre");
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      tick(4'b0110, 4'b0000, 1'b0, "t4_g");
      pulses += int'(s2_changed);
    end
    for (int i = 0; i < 6; i++) begin
      tick(4'b0110, 4'b1111, 1'b0, "t4_r");
      pulses += int'(s2_changed);
    end
    check_eq("t4_pulses", pulses, 0);
    check_eq("t4_s2", s2, 4'b1111);
    check_eq("t4_settled", settled, 1'b1);

    // 5: reset during a pending change, then full re-qualification
    hold(4'b0000, 4'b1111, 7, "t5_pre");
    hold(4'b1001, 4'b1111, 2, "t5_pend");
    tick(4'b1001, 4'b1111, 1'b1, "t5_rst");
    tick(4'b1001, 4'b1111, 1'b1, "t5_rst");
    check_eq("t5_s1_rst", s1, 4'h0);
    for (int i = 1; i <= 5; i++) begin
      tick(4'b1001, 4'b1111, 1'b0, "t5");
      if (i == 4) check_eq("t5_s1_edge4", s1, 4'h0);
    end
    check_eq("t5_s1_edge5", s1, 4'b1001);
    check_eq("t5_s1_changed", s1_changed, 1'b1);

    // 6: simultaneous change on both banks
    hold(4'b0000, 4'b0000, 7, "t6_pre");
    for (int i = 1; i <= 5; i++) tick(4'b0011, 4'b1100, 1'b0, "t6");
    check_eq("t6_vals", {s1, s2}, 8'b0011_1100);
    check_eq("t6_strobes", {s1_changed, s2_changed}, 2'b11);

    // Random bouncing inputs with occasional reset
    r1 = 4'h0;
    r2 = 4'h0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r1 = W'($urandom);
      if ($urandom_range(0, 3) == 0) r2 = W'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick(r1, r2, rst, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
